// File: rtl/lockin_acq_sequencer.sv
// lockin_acq_sequencer: sequencer for the lock-in reference multiplier.
// It latches M/N on start and pulses the multiplier reset so the reference phase restarts at 0.
// It gates exactly N*M ADC samples into the multiplier, then injects FLUSH_LEN zero samples to drain it.
// It flags exactly N*M products for the downstream accumulator.
// Optional feature macro: LOCKIN_TRIG_SYNC_EN. When it is defined, a trigger input is added
// and ARM waits for a synchronised rising edge on it.
module lockin_acq_sequencer #(
  parameter int FLUSH_LEN      = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_PTOS       = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
`ifdef LOCKIN_TRIG_SYNC_EN
  input  logic        trigger,
`endif
  input  logic [15:0] cfg_ptos_x_ciclo,
  input  logic [15:0] cfg_n_ciclos,
  input  logic [31:0] data,
  input  logic        data_valid,
  input  logic        mult_valid_in,
  output logic        mult_reset_n,
  output logic        mult_enable,
  output logic [15:0] mult_ptos_x_ciclo,
  output logic [31:0] mult_data,
  output logic        mult_data_valid,
  output logic        out_accept,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] sample_count
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_RUN, S_FLUSH, S_WAIT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           clr_cnt_q, clr_cnt_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [15:0]    m_q, m_d, n_q, n_d;
  logic [31:0]    total_q, total_d;
  logic [15:0]    phase_q, phase_d, cycle_q, cycle_d;
  logic [31:0]    result_cnt_q, result_cnt_d;
  logic [31:0]    sample_count_q, sample_count_d;
  logic           mult_reset_n_q, mult_reset_n_d;
  logic           mult_enable_q, mult_enable_d;
  logic [31:0]    mult_data_q, mult_data_d;
  logic           mult_data_valid_q, mult_data_valid_d;
  logic           out_accept_q, out_accept_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           cfg_bad;
  logic           arm_go;

`ifdef LOCKIN_TRIG_SYNC_EN
  logic [2:0] trig_sync_q;
  // Two synchroniser flops plus one history flop for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) trig_sync_q <= '0;
    else       trig_sync_q <= {trig_sync_q[1:0], trigger};
  end
  assign arm_go = trig_sync_q[1] & ~trig_sync_q[2];
`else
  assign arm_go = 1'b1;
`endif

  assign cfg_bad = (cfg_ptos_x_ciclo == 16'd0) || (cfg_n_ciclos == 16'd0) ||
                   ({1'b0, cfg_ptos_x_ciclo} > 17'(MAX_PTOS));

  // Next-state and registered-output logic; abort overrides everything and drops a concurrent start.
  always_comb begin
    state_d           = state_q;
    clr_cnt_d         = clr_cnt_q;
    flush_cnt_d       = flush_cnt_q;
    timer_d           = timer_q;
    m_d               = m_q;
    n_d               = n_q;
    total_d           = total_q;
    phase_d           = phase_q;
    cycle_d           = cycle_q;
    result_cnt_d      = result_cnt_q;
    sample_count_d    = sample_count_q;
    mult_data_d       = mult_data_q;
    mult_data_valid_d = 1'b0;
    out_accept_d      = 1'b0;
    done_d            = 1'b0;
    error_d           = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              error_d = 1'b1;
            end else begin
              m_d            = cfg_ptos_x_ciclo;
              n_d            = cfg_n_ciclos;
              total_d        = 32'(cfg_ptos_x_ciclo) * 32'(cfg_n_ciclos);
              clr_cnt_d      = 1'b0;
              sample_count_d = '0;
              phase_d        = '0;
              cycle_d        = '0;
              result_cnt_d   = '0;
              state_d        = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          sample_count_d = '0;
          phase_d        = '0;
          cycle_d        = '0;
          result_cnt_d   = '0;
          clr_cnt_d      = 1'b1;
          if (clr_cnt_q) state_d = S_ARM;
        end
        S_ARM: begin
          if (arm_go) state_d = S_RUN;
        end
        S_RUN: begin
          if (data_valid) begin
            mult_data_d       = data;
            mult_data_valid_d = 1'b1;
            sample_count_d    = sample_count_q + 32'd1;
            if (phase_q == m_q - 16'd1) begin
              phase_d = '0;
              cycle_d = cycle_q + 16'd1;
              if (cycle_q == n_q - 16'd1) begin
                flush_cnt_d = '0;
                timer_d     = '0;
                state_d     = S_FLUSH;
              end
            end else begin
              phase_d = phase_q + 16'd1;
            end
          end
        end
        S_FLUSH: begin
          mult_data_d       = '0;
          mult_data_valid_d = 1'b1;
          timer_d           = timer_q + 1'b1;
          flush_cnt_d       = flush_cnt_q + 1'b1;
          if (timer_q == TIMEOUT_LAST) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (flush_cnt_q == FLUSH_LAST) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          timer_d = timer_q + 1'b1;
          if (result_cnt_q == total_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (timer_q == TIMEOUT_LAST) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // Products are only counted while the window or its drain is in flight.
      if ((state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_WAIT)) begin
        if (mult_valid_in && (result_cnt_q < total_q)) begin
          out_accept_d = 1'b1;
          result_cnt_d = result_cnt_q + 32'd1;
        end
      end
    end

    mult_reset_n_d = (state_d != S_CLEAR);
    mult_enable_d  = (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_WAIT);
    busy_d         = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      clr_cnt_q         <= 1'b0;
      flush_cnt_q       <= '0;
      timer_q           <= '0;
      m_q               <= '0;
      n_q               <= '0;
      total_q           <= '0;
      phase_q           <= '0;
      cycle_q           <= '0;
      result_cnt_q      <= '0;
      sample_count_q    <= '0;
      mult_reset_n_q    <= 1'b0;
      mult_enable_q     <= 1'b0;
      mult_data_q       <= '0;
      mult_data_valid_q <= 1'b0;
      out_accept_q      <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      clr_cnt_q         <= clr_cnt_d;
      flush_cnt_q       <= flush_cnt_d;
      timer_q           <= timer_d;
      m_q               <= m_d;
      n_q               <= n_d;
      total_q           <= total_d;
      phase_q           <= phase_d;
      cycle_q           <= cycle_d;
      result_cnt_q      <= result_cnt_d;
      sample_count_q    <= sample_count_d;
      mult_reset_n_q    <= mult_reset_n_d;
      mult_enable_q     <= mult_enable_d;
      mult_data_q       <= mult_data_d;
      mult_data_valid_q <= mult_data_valid_d;
      out_accept_q      <= out_accept_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
    end
  end

  assign mult_reset_n      = mult_reset_n_q;
  assign mult_enable       = mult_enable_q;
  assign mult_ptos_x_ciclo = m_q;
  assign mult_data         = mult_data_q;
  assign mult_data_valid   = mult_data_valid_q;
  assign out_accept        = out_accept_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign sample_count      = sample_count_q;

endmodule

// File: tb/tb_lockin_acq_sequencer.sv
// Scoreboard bench for lockin_acq_sequencer with a behavioural multiplier model.
module tb_lockin_acq_sequencer;
  localparam int FLUSH_LEN      = 5;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int MAX_PTOS       = 2048;
  localparam int MULT_LAT       = 3;
  localparam int TRIG_DELAY     = 47;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_ptos_x_ciclo = '0;
  logic [15:0] cfg_n_ciclos = '0;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        mult_valid_in = 1'b0;
`ifdef LOCKIN_TRIG_SYNC_EN
  logic        trigger = 1'b0;
`endif
  logic        mult_reset_n, mult_enable, mult_data_valid, out_accept, busy, done, error;
  logic [15:0] mult_ptos_x_ciclo;
  logic [31:0] mult_data, sample_count;

  lockin_acq_sequencer #(
    .FLUSH_LEN(FLUSH_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_PTOS(MAX_PTOS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
`ifdef LOCKIN_TRIG_SYNC_EN
    .trigger(trigger),
`endif
    .cfg_ptos_x_ciclo(cfg_ptos_x_ciclo), .cfg_n_ciclos(cfg_n_ciclos),
    .data(data), .data_valid(data_valid), .mult_valid_in(mult_valid_in),
    .mult_reset_n(mult_reset_n), .mult_enable(mult_enable),
    .mult_ptos_x_ciclo(mult_ptos_x_ciclo), .mult_data(mult_data),
    .mult_data_valid(mult_data_valid), .out_accept(out_accept), .busy(busy),
    .done(done), .error(error), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] val; bit last; } fwd_t;
  typedef struct { int kind; int lat; } evt_t;   // kind 1 = done, 2 = error
  fwd_t fwd_q[$];
  evt_t evt_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, last_win_cyc = 0;
  int acc_cnt = 0, clr_cnt = 0, clr_exp = 0, low_run = 0;
  bit mon_en = 1'b0, tie_low = 1'b0;
  int last_m = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multiplier: a pipeline that only advances on valid samples.
  initial begin
    bit pipe [MULT_LAT];
    forever begin
      @(negedge clock);
      if (!mult_reset_n) begin
        for (int i = 0; i < MULT_LAT; i++) pipe[i] = 1'b0;
        mult_valid_in = 1'b0;
      end else if (mult_enable && mult_data_valid) begin
        mult_valid_in = pipe[MULT_LAT-1] && !tie_low;
        for (int i = MULT_LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = 1'b1;
      end else begin
        mult_valid_in = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a sample, product or completion event.
  initial begin
    fwd_t f;
    evt_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (mon_en) begin
        if (mult_data_valid) begin
          if (fwd_q.size() == 0) chk("fwd_unexpected", fwd_q.size(), 1);
          else begin
            f = fwd_q.pop_front();
            chk("fwd_data", mult_data, f.val);
            if (f.last) last_win_cyc = cyc;
          end
        end
        if (out_accept) acc_cnt++;
        if (!mult_reset_n) low_run++;
        else if (low_run != 0) begin
          chk("clear_len", low_run, 2);
          clr_cnt++;
          low_run = 0;
        end
        if (done || error) begin
          if (evt_q.size() == 0) chk("evt_unexpected", evt_q.size(), 1);
          else begin
            e = evt_q.pop_front();
            chk("evt_kind", done ? 1 : 2, e.kind);
            if (e.lat >= 0) chk("timeout_lat", cyc - last_win_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic drive_junk();
    data       = 32'hBAD0_0000 | $urandom_range(0, 255);
    data_valid = 1'($urandom_range(0, 1));
    @(negedge clock);
  endtask

  // One acquisition: gap_mode 0 = every cycle, 1 = every third cycle, 2 = random.
  task automatic run_acq(input int m, input int n, input int gap_mode,
                         input int abort_after, input bit tl);
    int total, sent, k, budget;
    bit bad, valid;
    evt_t ev;
    fwd_t f;
    total = m * n; sent = 0; k = 0; budget = 0;
    tie_low = tl;
    bad = (m == 0) || (m > MAX_PTOS) || (n == 0);
    @(negedge clock);
    start = 1'b1; data_valid = 1'b0;
    cfg_ptos_x_ciclo = 16'(m); cfg_n_ciclos = 16'(n);
    if (bad) begin
      ev.kind = 2; ev.lat = -1; evt_q.push_back(ev);
    end
    @(negedge clock);
    start = 1'b0;
    if (bad) begin
      chk("busy_badcfg", busy, 0);
      repeat (3) @(negedge clock);
      chk("evt_badcfg_seen", evt_q.size(), 0);
      chk("ptos_unchanged", mult_ptos_x_ciclo, last_m);
      $display("txn badcfg M=%0d N=%0d", m, n);
      return;
    end
    clr_exp++;
    acc_cnt = 0;
`ifdef LOCKIN_TRIG_SYNC_EN
    repeat (TRIG_DELAY) drive_junk();
    trigger = 1'b1;
`endif
    repeat (3) drive_junk();
    while (sent < total) begin
      if (abort_after >= 0 && sent == abort_after) break;
      case (gap_mode)
        0:       valid = 1'b1;
        1:       valid = (k % 3 == 0);
        default: valid = ($urandom_range(0, 2) != 0);
      endcase
      start = (gap_mode == 2 && k == 2);   // must be ignored outside IDLE
      data_valid = valid;
      data = $urandom;
      if (valid) begin
        sent++;
        f.val = data; f.last = (sent == total); fwd_q.push_back(f);
      end
      k++;
      @(negedge clock);
    end
    start = 1'b0;
    if (abort_after >= 0 && sent < total) begin
      abort = 1'b1; data_valid = 1'b1;
      @(negedge clock);
      abort = 1'b0; data_valid = 1'b0;
      @(negedge clock);
      chk("abort_busy", busy, 0);
      chk("abort_enable", mult_enable, 0);
      chk("abort_fwd_valid", mult_data_valid, 0);
      chk("abort_fwd_drained", fwd_q.size(), 0);
      repeat (4) drive_junk();
      $display("txn abort M=%0d N=%0d after=%0d", m, n, sent);
    end else begin
      for (int i = 0; i < FLUSH_LEN; i++) begin
        f.val = '0; f.last = 1'b0; fwd_q.push_back(f);
      end
      ev.kind = tl ? 2 : 1;
      ev.lat  = tl ? TIMEOUT_CYCLES : -1;
      evt_q.push_back(ev);
      while (evt_q.size() != 0 && budget < 3000) begin
        drive_junk();
        budget++;
      end
      chk("evt_wait_bound", evt_q.size(), 0);
      @(negedge clock);
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_enable", mult_enable, 0);
      chk("sample_count", sample_count, total);
      chk("accept_count", acc_cnt, tl ? 0 : total);
      chk("fwd_drained", fwd_q.size(), 0);
      chk("ptos_latched", mult_ptos_x_ciclo, m);
      $display("txn acq M=%0d N=%0d gap=%0d tie_low=%0d samples=%0d accepts=%0d",
               m, n, gap_mode, tl, sample_count, acc_cnt);
    end
    last_m = m;
`ifdef LOCKIN_TRIG_SYNC_EN
    trigger = 1'b0;
`endif
    tie_low = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_mult_reset_n", mult_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", mult_enable, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_ptos", mult_ptos_x_ciclo, 0);
    chk("rst_valid", mult_data_valid, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_mult_reset_n", mult_reset_n, 1);
    $display("txn reset released");
    mon_en = 1'b1;

    run_acq(8, 2, 0, -1, 1'b0);
    run_acq(4, 3, 1, -1, 1'b0);
    run_acq(0, 5, 0, -1, 1'b0);
    run_acq(4096, 1, 0, -1, 1'b0);
    run_acq(MAX_PTOS + 1, 1, 0, -1, 1'b0);
    run_acq(4, 0, 0, -1, 1'b0);
    run_acq(16, 4, 0, 20, 1'b0);
    run_acq(8, 1, 0, -1, 1'b0);
    run_acq(8, 1, 0, -1, 1'b1);

    // start and abort together: start must be dropped
    @(negedge clock);
    start = 1'b1; abort = 1'b1; cfg_ptos_x_ciclo = 16'd4; cfg_n_ciclos = 16'd1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_ptos", mult_ptos_x_ciclo, last_m);
    $display("txn start+abort dropped");

    run_acq(1, 3, 2, -1, 1'b0);
    run_acq(MAX_PTOS, 1, 0, -1, 1'b0);
    for (int r = 0; r < 6; r++)
      run_acq($urandom_range(1, 12), $urandom_range(1, 4), 2, -1, 1'b0);

    repeat (5) @(negedge clock);
    chk("clear_count", clr_cnt, clr_exp);
    chk("evt_left", evt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
